// File: rtl/bin2bcd_dabble.sv
// ============================================================================
//  Module   : bin2bcd_dabble
//  Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit
//             per clock, framed by a start/busy/done handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_dabble #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o,
    output logic                    overflow_o
);

    localparam int c_BCD_W = 4 * BCD_DIGITS;
    localparam int c_CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [c_BCD_W-1:0]   r_digits;
    logic [c_BCD_W-1:0]   w_adj;
    logic                 r_ovf_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_ovf;
    logic                 r_done;

    // Add-3 correction on every digit in parallel before the shift.
    generate
        for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_digit
            assign w_adj[4*k +: 4] = (r_digits[4*k +: 4] >= 4'd5)
                                   ? r_digits[4*k +: 4] + 4'd3
                                   : r_digits[4*k +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start_i) begin
                    w_next_state = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o = (r_state != c_S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_digits  <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start_i) begin
                        r_shift   <= bin_i;
                        r_digits  <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= c_CNT_W'(BIN_WIDTH);
                    end
                end
                c_S_SHIFT: begin
                    // The bit pushed out of the top digit marks value >= 10^BCD_DIGITS.
                    r_digits  <= {w_adj[c_BCD_W-2:0], r_shift[BIN_WIDTH-1]};
                    r_shift   <= r_shift << 1;
                    r_ovf_acc <= r_ovf_acc | w_adj[c_BCD_W-1];
                    r_cnt     <= r_cnt - c_CNT_W'(1);
                end
                c_S_DONE: begin
                    r_bcd  <= r_digits;
                    r_ovf  <= r_ovf_acc;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done_o     = r_done;
    assign bcd_o      = r_bcd;
    assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_dabble.sv
// ============================================================================
//  Module   : tb_bin2bcd_dabble
//  Brief    : Self-checking bench for bin2bcd_dabble against a decimal model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_dabble;

    logic clk = 1'b0;
    logic rst;

    logic        a_start, a_busy, a_done, a_ovf;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;
    logic        b_start, b_busy, b_done, b_ovf;
    logic [7:0]  b_bin;
    logic [7:0]  b_bcd;
    logic        c_start, c_busy, c_done, c_ovf;
    logic [15:0] c_bin;
    logic [19:0] c_bcd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_dabble dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .bin_i(a_bin),
        .busy_o(a_busy), .done_o(a_done), .bcd_o(a_bcd), .overflow_o(a_ovf)
    );

    bin2bcd_dabble #(.BIN_WIDTH(8), .BCD_DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .bin_i(b_bin),
        .busy_o(b_busy), .done_o(b_done), .bcd_o(b_bcd), .overflow_o(b_ovf)
    );

    bin2bcd_dabble #(.BIN_WIDTH(16), .BCD_DIGITS(5)) dut_c (
        .clk(clk), .rst(rst), .start_i(c_start), .bin_i(c_bin),
        .busy_o(c_busy), .done_o(c_done), .bcd_o(c_bcd), .overflow_o(c_ovf)
    );

    // Decimal reference: digit k is (v / 10^k) mod 10.
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned p;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        return (v >= p);
    endfunction

    task automatic run_a(input logic [7:0] v, output logic [19:0] bcd,
                         output logic ovf, output int lat, output logic busy0);
        int g;
        g = 0;
        while (a_busy && g < 40) begin @(negedge clk); g++; end
        a_start = 1'b1;
        a_bin   = v;
        @(negedge clk);
        a_start = 1'b0;
        busy0   = a_busy & ~a_done;
        lat     = 0;
        while (!a_done && lat < 60) begin @(negedge clk); lat++; end
        bcd = {8'h00, a_bcd};
        ovf = a_ovf;
    endtask

    task automatic run_b(input logic [7:0] v, output logic [19:0] bcd,
                         output logic ovf, output int lat);
        int g;
        g = 0;
        while (b_busy && g < 40) begin @(negedge clk); g++; end
        b_start = 1'b1;
        b_bin   = v;
        @(negedge clk);
        b_start = 1'b0;
        lat     = 0;
        while (!b_done && lat < 60) begin @(negedge clk); lat++; end
        bcd = {12'h000, b_bcd};
        ovf = b_ovf;
    endtask

    task automatic run_c(input logic [15:0] v, output logic [19:0] bcd,
                         output logic ovf, output int lat);
        int g;
        g = 0;
        while (c_busy && g < 40) begin @(negedge clk); g++; end
        c_start = 1'b1;
        c_bin   = v;
        @(negedge clk);
        c_start = 1'b0;
        lat     = 0;
        while (!c_done && lat < 60) begin @(negedge clk); lat++; end
        bcd = c_bcd;
        ovf = c_ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
        checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", a_bcd); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
        checks++; if (c_bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd_wide got=%h exp=00000", c_bcd); end
    endtask

    task automatic test_max_value();
        logic [19:0] bcd; logic ovf; int lat; logic busy0;
        run_a(8'd255, bcd, ovf, lat, busy0);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL max_busy_rise got=%b exp=1", busy0); end
        checks++; if (lat != 9) begin errors++; $display("FAIL max_latency got=%0d exp=9", lat); end
        checks++; if (bcd !== 20'h00255) begin errors++; $display("FAIL max_bcd got=%h exp=00255", bcd); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got=%b exp=0", ovf); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL max_idle_at_done got=%b exp=0", a_busy); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bcd; logic ovf; int lat; logic busy0;
        logic [7:0] vals [3];
        vals[0] = 8'd0; vals[1] = 8'd99; vals[2] = 8'd100;
        for (int i = 0; i < 3; i++) begin
            run_a(vals[i], bcd, ovf, lat, busy0);
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, busy0); end
            checks++; if (lat != 9) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=9", i, lat); end
            checks++; if (bcd !== ref_bcd(vals[i], 3)) begin errors++; $display("FAIL b2b_bcd[%0d] got=%h exp=%h", i, bcd, ref_bcd(vals[i], 3)); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf[%0d] got=%b exp=0", i, ovf); end
        end
    endtask

    task automatic test_hold_start();
        int t, t2;
        a_start = 1'b1;
        a_bin   = 8'd42;
        @(negedge clk);
        t = 0;
        while (!a_done && t < 60) begin
            @(negedge clk);
            t++;
            if (t == 3) a_bin = 8'd7;
        end
        checks++; if (t != 9) begin errors++; $display("FAIL hold_first_latency got=%0d exp=9", t); end
        checks++; if (a_bcd !== 12'h042) begin errors++; $display("FAIL hold_first_bcd got=%h exp=042", a_bcd); end
        t2 = 0;
        do begin @(negedge clk); t2++; end while (!a_done && t2 < 60);
        a_start = 1'b0;
        checks++; if (t2 != 10) begin errors++; $display("FAIL hold_second_gap got=%0d exp=10", t2); end
        checks++; if (a_bcd !== 12'h007) begin errors++; $display("FAIL hold_second_bcd got=%h exp=007", a_bcd); end
    endtask

    task automatic test_reset_abort();
        logic [19:0] bcd; logic ovf; int lat; logic busy0;
        logic seen;
        a_start = 1'b1;
        a_bin   = 8'd200;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", a_done); end
        checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL abort_bcd got=%h exp=000", a_bcd); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b exp=0", a_ovf); end
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (a_done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        run_a(8'd200, bcd, ovf, lat, busy0);
        checks++; if (lat != 9) begin errors++; $display("FAIL abort_fresh_latency got=%0d exp=9", lat); end
        checks++; if (bcd !== 20'h00200) begin errors++; $display("FAIL abort_fresh_bcd got=%h exp=00200", bcd); end
    endtask

    task automatic test_random_default();
        logic [19:0] bcd; logic ovf; int lat; logic busy0;
        logic [7:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom_range(0, 255));
            run_a(v, bcd, ovf, lat, busy0);
            checks++; if (lat != 9) begin errors++; $display("FAIL rand_latency v=%0d got=%0d exp=9", v, lat); end
            checks++; if (bcd !== ref_bcd(v, 3)) begin errors++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v, 3)); end
            checks++; if (ovf !== ref_ovf(v, 3)) begin errors++; $display("FAIL rand_ovf v=%0d got=%b exp=%b", v, ovf, ref_ovf(v, 3)); end
        end
    endtask

    task automatic test_undersized();
        logic [19:0] bcd; logic ovf; int lat;
        logic [7:0] v;
        run_b(8'd200, bcd, ovf, lat);
        checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL small_200_bcd got=%h exp=00000", bcd); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL small_200_ovf got=%b exp=1", ovf); end
        run_b(8'd99, bcd, ovf, lat);
        checks++; if (bcd !== 20'h00099) begin errors++; $display("FAIL small_99_bcd got=%h exp=00099", bcd); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL small_99_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom_range(0, 255));
            run_b(v, bcd, ovf, lat);
            checks++; if (lat != 9) begin errors++; $display("FAIL small_rand_latency v=%0d got=%0d exp=9", v, lat); end
            checks++; if (bcd !== ref_bcd(v, 2)) begin errors++; $display("FAIL small_rand_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v, 2)); end
            checks++; if (ovf !== ref_ovf(v, 2)) begin errors++; $display("FAIL small_rand_ovf v=%0d got=%b exp=%b", v, ovf, ref_ovf(v, 2)); end
        end
    endtask

    task automatic test_wide();
        logic [19:0] bcd; logic ovf; int lat;
        logic [15:0] v;
        int unsigned edges [7];
        edges[0] = 0; edges[1] = 1; edges[2] = 9; edges[3] = 10;
        edges[4] = 9999; edges[5] = 10000; edges[6] = 65535;
        for (int i = 0; i < 1507; i++) begin
            v = (i < 7) ? 16'(edges[i]) : 16'($urandom_range(0, 65535));
            run_c(v, bcd, ovf, lat);
            checks++; if (lat != 17) begin errors++; $display("FAIL wide_latency v=%0d got=%0d exp=17", v, lat); end
            checks++; if (bcd !== ref_bcd(v, 5)) begin errors++; $display("FAIL wide_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v, 5)); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wide_ovf v=%0d got=%b exp=0", v, ovf); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0; a_bin = '0;
        b_start = 1'b0; b_bin = '0;
        c_start = 1'b0; c_bin = '0;
        test_reset();
        test_max_value();
        test_back_to_back();
        test_hold_start();
        test_reset_abort();
        test_random_default();
        test_undersized();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
